// File: rtl/fifo_ctrl.sv
// fifo_ctrl -- pointer, occupancy and flag controller for an external
// first-word-fall-through FIFO storage array of 2**ADDR_WIDTH entries.
//
// Ports:
//   clk          in   rising-edge clock
//   reset_n      in   asynchronous active-low reset
//   wr           in   producer write request
//   rd           in   consumer read request / head-word acknowledge
//   w_en         out  storage write enable (combinational: wr & ~full)
//   w_addr       out  storage write address (write pointer)
//   r_addr       out  storage read address (read pointer, head word)
//   full         out  registered, count == depth
//   empty        out  registered, count == 0
//   count        out  registered occupancy, 0..depth
//   almost_full  out  registered, count >= AF_LEVEL
//   almost_empty out  registered, count <= AE_LEVEL
//   overflow     out  registered pulse: write while full with no read accepted
//   underflow    out  registered pulse: read while empty
module fifo_ctrl #(
   parameter int ADDR_WIDTH = 3,
   parameter int AF_LEVEL   = 6,
   parameter int AE_LEVEL   = 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  wr,
   input  logic                  rd,
   output logic                  w_en,
   output logic [ADDR_WIDTH-1:0] w_addr,
   output logic [ADDR_WIDTH-1:0] r_addr,
   output logic                  full,
   output logic                  empty,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int unsigned           LP_DEPTH = 2**ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0]   LP_DEPTH_C = (ADDR_WIDTH+1)'(LP_DEPTH);
   localparam logic [ADDR_WIDTH:0]   LP_AF_C    = (ADDR_WIDTH+1)'(AF_LEVEL);
   localparam logic [ADDR_WIDTH:0]   LP_AE_C    = (ADDR_WIDTH+1)'(AE_LEVEL);
   localparam logic [ADDR_WIDTH:0]   LP_CNT_ONE = (ADDR_WIDTH+1)'(1);
   localparam logic [ADDR_WIDTH-1:0] LP_PTR_ONE = (ADDR_WIDTH)'(1);

   logic [ADDR_WIDTH-1:0] r_wptr;
   logic [ADDR_WIDTH-1:0] r_rptr;
   logic [ADDR_WIDTH:0]   r_count;
   logic                  r_full;
   logic                  r_empty;
   logic                  r_af;
   logic                  r_ae;
   logic                  r_ovf;
   logic                  r_udf;

   logic                  w_wr_acc;
   logic                  w_rd_acc;
   logic [ADDR_WIDTH:0]   w_count_nxt;

   assign w_wr_acc = wr & ~r_full;
   assign w_rd_acc = rd & ~r_empty;

   always_comb begin
      w_count_nxt = r_count;
      case ({w_wr_acc, w_rd_acc})
         2'b10:   w_count_nxt = r_count + LP_CNT_ONE;
         2'b01:   w_count_nxt = r_count - LP_CNT_ONE;
         default: w_count_nxt = r_count;
      endcase
   end

   // Flags are derived from the next count; this matches the per-case
   // set/clear rules since a simultaneous read+write leaves the count unchanged.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_full  <= 1'b0;
         r_empty <= 1'b1;
         r_af    <= 1'b0;
         r_ae    <= 1'b1;
         r_ovf   <= 1'b0;
         r_udf   <= 1'b0;
      end else begin
         if (w_wr_acc) r_wptr <= r_wptr + LP_PTR_ONE;
         if (w_rd_acc) r_rptr <= r_rptr + LP_PTR_ONE;
         r_count <= w_count_nxt;
         r_full  <= (w_count_nxt == LP_DEPTH_C);
         r_empty <= (w_count_nxt == '0);
         r_af    <= (w_count_nxt >= LP_AF_C);
         r_ae    <= (w_count_nxt <= LP_AE_C);
         // A write while full is only an overflow if no read frees a slot
         // in the same cycle (the write is still dropped either way).
         r_ovf   <= wr & r_full & ~w_rd_acc;
         r_udf   <= rd & r_empty;
      end
   end

   assign w_en         = w_wr_acc;
   assign w_addr       = r_wptr;
   assign r_addr       = r_rptr;
   assign full         = r_full;
   assign empty        = r_empty;
   assign count        = r_count;
   assign almost_full  = r_af;
   assign almost_empty = r_ae;
   assign overflow     = r_ovf;
   assign underflow    = r_udf;

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl -- directed bench for fifo_ctrl with a behavioural storage
// array and a data scoreboard for the first-word-fall-through head word.
module tb_fifo_ctrl;

   localparam int DEPTH = 8;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       wr;
   logic       rd;
   logic       w_en;
   logic [2:0] w_addr;
   logic [2:0] r_addr;
   logic       full;
   logic       empty;
   logic [3:0] count;
   logic       almost_full;
   logic       almost_empty;
   logic       overflow;
   logic       underflow;

   int checks = 0;
   int errors = 0;

   logic [7:0] mem [0:DEPTH-1];
   logic [7:0] q [$];
   logic [7:0] wdata = 8'h10;

   int m_cnt = 0;
   int m_wp  = 0;
   int m_rp  = 0;

   always #5 clk = ~clk;

   fifo_ctrl #(.ADDR_WIDTH(3), .AF_LEVEL(6), .AE_LEVEL(1)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .wr           (wr),
      .rd           (rd),
      .w_en         (w_en),
      .w_addr       (w_addr),
      .r_addr       (r_addr),
      .full         (full),
      .empty        (empty),
      .count        (count),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_values(input string tag);
      chk({tag, "_waddr"}, w_addr, 0);
      chk({tag, "_raddr"}, r_addr, 0);
      chk({tag, "_count"}, count, 0);
      chk({tag, "_empty"}, empty, 1);
      chk({tag, "_full"}, full, 0);
      chk({tag, "_ae"}, almost_empty, 1);
      chk({tag, "_af"}, almost_full, 0);
      chk({tag, "_ovf"}, overflow, 0);
      chk({tag, "_udf"}, underflow, 0);
   endtask

   // One clock cycle, entered and left just after a falling edge.
   task automatic step(input logic iw, input logic ir);
      logic       exp_wen;
      logic       rd_acc;
      logic       exp_ovf;
      logic       exp_udf;
      logic       cap_we;
      logic [2:0] cap_wa;
      logic [7:0] exp_head;
      wr = iw;
      rd = ir;
      #1;
      exp_wen = iw && (m_cnt != DEPTH);
      rd_acc  = ir && (m_cnt != 0);
      exp_ovf = iw && (m_cnt == DEPTH) && !rd_acc;
      exp_udf = ir && (m_cnt == 0);
      chk("w_en", w_en, exp_wen);
      chk("w_addr", w_addr, m_wp);
      chk("r_addr", r_addr, m_rp);
      if (rd_acc) begin
         exp_head = q.pop_front();
         chk("head_word", mem[r_addr], exp_head);
      end
      cap_we = w_en;
      cap_wa = w_addr;
      if (exp_wen) q.push_back(wdata);
      @(posedge clk);
      if (cap_we === 1'b1) begin
         mem[cap_wa] = wdata;
      end
      if (exp_wen) wdata = wdata + 8'd1;
      if (exp_wen) m_wp = (m_wp + 1) % DEPTH;
      if (rd_acc)  m_rp = (m_rp + 1) % DEPTH;
      m_cnt = m_cnt + (exp_wen ? 1 : 0) - (rd_acc ? 1 : 0);
      #1;
      chk("count", count, m_cnt);
      chk("full", full, m_cnt == DEPTH);
      chk("empty", empty, m_cnt == 0);
      chk("almost_full", almost_full, m_cnt >= 6);
      chk("almost_empty", almost_empty, m_cnt <= 1);
      chk("overflow", overflow, exp_ovf);
      chk("underflow", underflow, exp_udf);
      chk("full_empty_excl", full & empty, 0);
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      reset_n = 1'b1;
      wr = 1'b0;
      rd = 1'b0;
      #1 reset_n = 1'b0;
      #2;
      chk_reset_values("por");
      @(negedge clk);
      reset_n = 1'b1;

      // Fill: addresses 0..7, almost_full from count 6, full after 8.
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0);
      chk("fill_full", full, 1);
      chk("fill_count", count, 8);
      chk("fill_waddr_wrap", w_addr, 0);
      step(1'b1, 1'b0);
      chk("ovf_pulse", overflow, 1);
      step(1'b0, 1'b0);
      chk("ovf_clear", overflow, 0);

      // Drain: head words in order, underflow on the extra read.
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1);
      chk("drain_empty", empty, 1);
      step(1'b0, 1'b1);
      chk("udf_pulse", underflow, 1);
      chk("udf_raddr", r_addr, 0);
      step(1'b0, 1'b0);
      chk("udf_clear", underflow, 0);

      // Simultaneous request while empty: only the write lands.
      step(1'b1, 1'b1);
      chk("we_count", count, 1);
      chk("we_empty", empty, 0);
      chk("we_udf", underflow, 1);
      step(1'b0, 1'b0);

      // Simultaneous request while full: only the read lands.
      for (int i = 0; i < 7; i++) step(1'b1, 1'b0);
      chk("re_pre_full", full, 1);
      step(1'b1, 1'b1);
      chk("re_count", count, 7);
      chk("re_full", full, 0);
      chk("re_ovf", overflow, 0);

      // Steady state at count 4 with pointers wrapping.
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
      for (int i = 0; i < 10; i++) step(1'b1, 1'b1);
      chk("ss_count", count, 4);

      // Mixed traffic.
      for (int i = 0; i < 40; i++) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

      // Bring to count 5, then reset between edges.
      while (m_cnt < 5) step(1'b1, 1'b0);
      while (m_cnt > 5) step(1'b0, 1'b1);
      chk("mid_count5", count, 5);
      #2 reset_n = 1'b0;
      #1;
      chk_reset_values("mid");
      m_cnt = 0;
      m_wp  = 0;
      m_rp  = 0;
      q.delete();
      @(negedge clk);
      reset_n = 1'b1;
      step(1'b1, 1'b0);
      chk("post_rst_count", count, 1);
      step(1'b0, 1'b1);
      chk("post_rst_empty", empty, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
